// File: rtl/imm_decode_pipe.sv
// imm_decode_pipe: registered RV32I/RV64I immediate-decode stage with a two-entry skid buffer.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_flush               synchronous flush of both entries
//   i_in_valid/o_in_ready upstream handshake; o_in_ready is registered (NOT skid valid)
//   i_in_inst, i_in_pc    instruction word and its PC
//   o_out_valid/i_out_ready downstream handshake
//   o_out_inst, o_out_pc  registered instruction and PC
//   o_out_imm, o_out_fmt  decoded immediate and format (0=R/none 1=I 2=S 3=B 4=U 5=J)
//   o_out_illegal         unsupported opcode or non-32-bit encoding
//   o_illegal_cnt         saturating count of accepted illegal instructions
module imm_decode_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [31:0]      i_in_inst,
  input  logic [XLEN-1:0]  i_in_pc,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [31:0]      o_out_inst,
  output logic [XLEN-1:0]  o_out_pc,
  output logic [XLEN-1:0]  o_out_imm,
  output logic [2:0]       o_out_fmt,
  output logic             o_out_illegal,
  output logic [CNT_W-1:0] o_illegal_cnt
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpMisc   = 7'b0001111;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpImm32  = 7'b0011011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpOp32   = 7'b0111011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [2:0] FmtR = 3'd0;
  localparam logic [2:0] FmtI = 3'd1;
  localparam logic [2:0] FmtS = 3'd2;
  localparam logic [2:0] FmtB = 3'd3;
  localparam logic [2:0] FmtU = 3'd4;
  localparam logic [2:0] FmtJ = 3'd5;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } payload_t;

  // Every immediate fits in 32 bits; a signed cast widens it to XLEN.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_imm;
  logic [2:0]      w_fmt;
  logic            w_illegal;
  logic            w_accept;
  logic            w_drain;
  payload_t        w_new;

  payload_t        r_out;
  logic            r_out_valid;
  payload_t        r_skid;
  logic            r_skid_valid;
  logic [CNT_W-1:0] r_cnt;

  assign w_opcode = i_in_inst[6:0];
  assign w_funct3 = i_in_inst[14:12];

  always_comb begin
    w_imm     = '0;
    w_fmt     = FmtR;
    w_illegal = 1'b0;
    if (i_in_inst[1:0] != 2'b11) begin
      w_illegal = 1'b1;
    end else begin
      case (w_opcode)
        OpLoad, OpJalr, OpMisc, OpSystem: begin
          w_fmt = FmtI;
          w_imm = sext32({{20{i_in_inst[31]}}, i_in_inst[31:20]});
        end
        OpImm: begin
          if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
            // Shift immediates carry a zero-extended shamt, not a signed value.
            if (XLEN == 64) begin
              w_fmt = FmtI;
              w_imm = XLEN'(i_in_inst[25:20]);
            end else if (i_in_inst[25]) begin
              w_illegal = 1'b1;
            end else begin
              w_fmt = FmtI;
              w_imm = XLEN'(i_in_inst[24:20]);
            end
          end else begin
            w_fmt = FmtI;
            w_imm = sext32({{20{i_in_inst[31]}}, i_in_inst[31:20]});
          end
        end
        OpImm32: begin
          if (XLEN == 64) begin
            w_fmt = FmtI;
            w_imm = sext32({{20{i_in_inst[31]}}, i_in_inst[31:20]});
          end else begin
            w_illegal = 1'b1;
          end
        end
        OpStore: begin
          w_fmt = FmtS;
          w_imm = sext32({{20{i_in_inst[31]}}, i_in_inst[31:25], i_in_inst[11:7]});
        end
        OpBranch: begin
          w_fmt = FmtB;
          w_imm = sext32({{19{i_in_inst[31]}}, i_in_inst[31], i_in_inst[7],
                          i_in_inst[30:25], i_in_inst[11:8], 1'b0});
        end
        OpLui, OpAuipc: begin
          w_fmt = FmtU;
          w_imm = sext32({i_in_inst[31:12], 12'b0});
        end
        OpJal: begin
          w_fmt = FmtJ;
          w_imm = sext32({{11{i_in_inst[31]}}, i_in_inst[31], i_in_inst[19:12],
                          i_in_inst[20], i_in_inst[30:21], 1'b0});
        end
        OpOp: w_fmt = FmtR;
        OpOp32: w_illegal = (XLEN != 64);
        default: w_illegal = 1'b1;
      endcase
    end
  end

  assign w_new    = '{inst: i_in_inst, pc: i_in_pc, imm: w_imm, fmt: w_fmt, illegal: w_illegal};
  assign w_accept = i_in_valid & o_in_ready & ~i_flush;
  // Output slot is free this cycle: either empty or being consumed.
  assign w_drain  = ~r_out_valid | i_out_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else if (i_flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_drain) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= w_accept;
        if (w_accept) r_skid <= w_new;
      end else begin
        r_out_valid <= w_accept;
        if (w_accept) r_out <= w_new;
      end
    end else if (w_accept) begin
      r_skid       <= w_new;
      r_skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_accept && w_illegal && r_cnt != {CNT_W{1'b1}}) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_in_ready    = ~r_skid_valid;
  assign o_out_valid   = r_out_valid;
  assign o_out_inst    = r_out.inst;
  assign o_out_pc      = r_out.pc;
  assign o_out_imm     = r_out.imm;
  assign o_out_fmt     = r_out.fmt;
  assign o_out_illegal = r_out.illegal;
  assign o_illegal_cnt = r_cnt;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Self-checking bench: one XLEN=32/CNT_W=16 and one XLEN=64/CNT_W=2 instance share stimulus;
// each has its own expected-response queue drained by a monitor.
module tb_imm_decode_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic        rdy32, vld32, ill32;
  logic [31:0] inst32, pc32, imm32;
  logic [2:0]  fmt32;
  logic [15:0] cnt32;
  logic        rdy64, vld64, ill64;
  logic [31:0] inst64;
  logic [63:0] pc64, imm64;
  logic [2:0]  fmt64;
  logic [1:0]  cnt64;

  always #5 clk = ~clk;

  imm_decode_pipe #(.XLEN(32), .CNT_W(16)) u_dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(rdy32),
    .i_in_inst(in_inst), .i_in_pc(in_pc[31:0]), .o_out_valid(vld32), .i_out_ready(out_ready),
    .o_out_inst(inst32), .o_out_pc(pc32), .o_out_imm(imm32), .o_out_fmt(fmt32),
    .o_out_illegal(ill32), .o_illegal_cnt(cnt32)
  );

  imm_decode_pipe #(.XLEN(64), .CNT_W(2)) u_dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(rdy64),
    .i_in_inst(in_inst), .i_in_pc(in_pc), .o_out_valid(vld64), .i_out_ready(out_ready),
    .o_out_inst(inst64), .o_out_pc(pc64), .o_out_imm(imm64), .o_out_fmt(fmt64),
    .o_out_illegal(ill64), .o_illegal_cnt(cnt64)
  );

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
  } dir_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t cur32, cur64;
  int unsigned m_cnt32, m_cnt64;
  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference decode: immediate values built as signed integers from the field weights.
  task automatic ref_decode(input logic [31:0] i, input int xlen,
                            output logic [63:0] imm, output logic [2:0] fmt, output logic ill);
    longint v, s;
    v   = 0;
    fmt = 3'd0;
    ill = 1'b0;
    s   = i[31] ? 64'sd1 : 64'sd0;
    case (i[6:0])
      7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        fmt = 1; v = -s * 2048 + longint'(i[30:20]);
      end
      7'b0010011: begin
        fmt = 1;
        if (i[14:12] == 3'd1 || i[14:12] == 3'd5) begin
          if (xlen == 64) v = longint'(i[25:20]);
          else if (i[25]) ill = 1'b1;
          else v = longint'(i[24:20]);
        end else v = -s * 2048 + longint'(i[30:20]);
      end
      7'b0011011: begin
        if (xlen == 64) begin fmt = 1; v = -s * 2048 + longint'(i[30:20]); end
        else ill = 1'b1;
      end
      7'b0100011: begin
        fmt = 2; v = -s * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:7]);
      end
      7'b1100011: begin
        fmt = 3;
        v = -s * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
      end
      7'b0110111, 7'b0010111: begin
        fmt = 4; v = -s * 64'sd2147483648 + longint'(i[30:12]) * 4096;
      end
      7'b1101111: begin
        fmt = 5;
        v = -s * 1048576 + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
            + longint'(i[30:21]) * 2;
      end
      7'b0110011: fmt = 0;
      7'b0111011: ill = (xlen != 64);
      default: ill = 1'b1;
    endcase
    if (i[1:0] != 2'b11) ill = 1'b1;
    if (ill) begin fmt = 0; v = 0; end
    imm = (xlen == 32) ? {32'h0, v[31:0]} : v;
  endtask

  task automatic set_model(input logic [31:0] inst, input logic [63:0] pc);
    in_inst    = inst;
    in_pc      = pc;
    cur32.inst = inst; cur32.pc = {32'h0, pc[31:0]};
    cur64.inst = inst; cur64.pc = pc;
    ref_decode(inst, 32, cur32.imm, cur32.fmt, cur32.ill);
    ref_decode(inst, 64, cur64.imm, cur64.fmt, cur64.ill);
  endtask

  task automatic set_dir(input dir_t d, input logic [63:0] pc);
    in_inst    = d.inst;
    in_pc      = pc;
    cur32.inst = d.inst; cur32.pc = {32'h0, pc[31:0]};
    cur32.imm  = d.imm32; cur32.fmt = d.fmt32; cur32.ill = d.ill32;
    cur64.inst = d.inst; cur64.pc = pc;
    cur64.imm  = d.imm64; cur64.fmt = d.fmt64; cur64.ill = d.ill64;
  endtask

  // One clock with the current inputs; returns whether the word was accepted.
  task automatic step(output bit acc);
    bit fl;
    @(negedge clk);
    acc = in_valid && rdy32 && !flush;
    fl  = flush;
    @(posedge clk);
    #1;
    if (fl) begin
      q32.delete();
      q64.delete();
    end else if (acc) begin
      q32.push_back(cur32);
      q64.push_back(cur64);
      if (cur32.ill && m_cnt32 < 65535) m_cnt32++;
      if (cur64.ill && m_cnt64 < 3) m_cnt64++;
    end
  endtask

  task automatic send_until_accepted();
    bit acc;
    int budget;
    in_valid = 1'b1;
    acc      = 1'b0;
    budget   = 0;
    while (!acc && budget < 50) begin
      step(acc);
      budget++;
    end
    check("accept_timeout", {63'h0, acc}, 64'h1);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_vld32", {63'h0, vld32}, 64'h0);
    check("rst_vld64", {63'h0, vld64}, 64'h0);
    check("rst_rdy32", {63'h0, rdy32}, 64'h1);
    check("rst_rdy64", {63'h0, rdy64}, 64'h1);
    check("rst_imm", imm64 | {32'h0, imm32}, 64'h0);
    check("rst_fmt_ill", {58'h0, fmt32, fmt64, ill32, ill64}, 64'h0);
    check("rst_inst_pc", {32'h0, inst32 | inst64} | pc64 | {32'h0, pc32}, 64'h0);
    check("rst_cnt", {46'h0, cnt32, cnt64}, 64'h0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    q32.delete();
    q64.delete();
    m_cnt32 = 0;
    m_cnt64 = 0;
    #1;
    check_reset_state();
    @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      check("in_ready32", {63'h0, rdy32}, {63'h0, q32.size() < 2});
      check("in_ready64", {63'h0, rdy64}, {63'h0, q64.size() < 2});
      check("out_valid32", {63'h0, vld32}, {63'h0, q32.size() > 0});
      check("out_valid64", {63'h0, vld64}, {63'h0, q64.size() > 0});
      check("cnt32", {48'h0, cnt32}, 64'(m_cnt32));
      check("cnt64", {62'h0, cnt64}, 64'(m_cnt64));
      if (!flush && out_ready && vld32 && q32.size() > 0) begin
        e = q32.pop_front();
        check("inst32", {32'h0, inst32}, {32'h0, e.inst});
        check("pc32", {32'h0, pc32}, e.pc);
        check("imm32", {32'h0, imm32}, e.imm);
        check("fmt_ill32", {60'h0, fmt32, ill32}, {60'h0, e.fmt, e.ill});
      end
      if (!flush && out_ready && vld64 && q64.size() > 0) begin
        e = q64.pop_front();
        check("inst64", {32'h0, inst64}, {32'h0, e.inst});
        check("pc64", pc64, e.pc);
        check("imm64", imm64, e.imm);
        check("fmt_ill64", {60'h0, fmt64, ill64}, {60'h0, e.fmt, e.ill});
      end
    end
  end

  dir_t dir[12];
  logic [6:0] ops[16];

  initial begin
    bit acc;
    logic [31:0] w;
    dir[0]  = '{32'hFFF00093, 64'hFFFFFFFF, 1, 0, 64'hFFFFFFFFFFFFFFFF, 1, 0};
    dir[1]  = '{32'hFE112E23, 64'hFFFFFFFC, 2, 0, 64'hFFFFFFFFFFFFFFFC, 2, 0};
    dir[2]  = '{32'h0010006F, 64'h00000800, 5, 0, 64'h0000000000000800, 5, 0};
    dir[3]  = '{32'h123452B7, 64'h12345000, 4, 0, 64'h0000000012345000, 4, 0};
    dir[4]  = '{32'h800002B7, 64'h80000000, 4, 0, 64'hFFFFFFFF80000000, 4, 0};
    dir[5]  = '{32'h0000001B, 64'h0, 0, 1, 64'h0, 1, 0};
    dir[6]  = '{32'h00000000, 64'h0, 0, 1, 64'h0, 0, 1};
    dir[7]  = '{32'h02009013, 64'h0, 0, 1, 64'h20, 1, 0};
    dir[8]  = '{32'hFE000EE3, 64'hFFFFFFFC, 3, 0, 64'hFFFFFFFFFFFFFFFC, 3, 0};
    dir[9]  = '{32'h4030D093, 64'h3, 1, 0, 64'h3, 1, 0};
    dir[10] = '{32'h00000001, 64'h0, 0, 1, 64'h0, 0, 1};
    dir[11] = '{32'h0000003B, 64'h0, 0, 1, 64'h0, 0, 0};
    ops = '{7'b0000011, 7'b0001111, 7'b0010011, 7'b0010111, 7'b0011011, 7'b0100011,
            7'b0110011, 7'b0110111, 7'b0111011, 7'b1100011, 7'b1100111, 7'b1101111,
            7'b1110011, 7'b0010011, 7'b1111111, 7'b0101011};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    m_cnt32 = 0; m_cnt64 = 0;
    #2;
    check_reset_state();
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Directed decode values, downstream always ready.
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      set_dir(dir[k], {$urandom, $urandom});
      send_until_accepted();
    end
    // Saturate the 2-bit counter.
    for (int k = 0; k < 5; k++) begin
      set_dir(dir[6], 64'(k));
      send_until_accepted();
    end
    step(acc);

    // Stall: A held, B in skid, C waits until space frees up.
    out_ready = 1'b0;
    set_dir(dir[0], 64'hA); send_until_accepted();
    set_dir(dir[1], 64'hB); send_until_accepted();
    set_dir(dir[2], 64'hC);
    in_valid = 1'b1;
    step(acc);
    check("stall_c_blocked", {63'h0, acc}, 64'h0);
    out_ready = 1'b1;
    send_until_accepted();
    step(acc); step(acc); step(acc);

    // Flush with two entries held and an illegal word offered.
    out_ready = 1'b0;
    set_dir(dir[3], 64'h10); send_until_accepted();
    set_dir(dir[4], 64'h14); send_until_accepted();
    set_dir(dir[6], 64'h18);
    in_valid = 1'b1;
    flush    = 1'b1;
    step(acc);
    flush    = 1'b0;
    in_valid = 1'b0;
    step(acc);

    // Reset with two entries held and input still valid.
    set_dir(dir[5], 64'h20); send_until_accepted();
    set_dir(dir[7], 64'h24); send_until_accepted();
    set_dir(dir[6], 64'h28);
    in_valid = 1'b1;
    apply_reset();
    step(acc);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      w = $urandom;
      if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 15)];
      if ($urandom_range(0, 5) == 0) w[25] = 1'b1;
      set_model(w, {$urandom, $urandom});
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      step(acc);
    end
    flush = 1'b0;

    // Drain.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10 && q32.size() > 0; k++) step(acc);
    step(acc);
    check("drain_empty", 64'(q32.size() + q64.size()), 64'h0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
